// File: rtl/fp_norm_round.sv
// Iterative normalise-and-round for single-precision results: one shift per cycle,
// round-to-nearest-even, exponent saturates to infinity; valid/ready on both sides.
module fp_norm_round #(
  parameter int FRAC_W = 23,
  parameter int EXP_W  = 10,
  parameter int BIAS   = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FRAC_W+4:0] in_m,
  input  logic [EXP_W-1:0]  in_e,
  input  logic              in_s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W:0]   n_m,
  output logic [EXP_W-1:0]  n_e,
  output logic              n_s,
  output logic              inexact,
  output logic              overflow
);
  localparam int MW = FRAC_W + 5;
  localparam int EW = EXP_W + 1;
  localparam logic signed [EW-1:0] EMIN = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] EMAX = EW'(BIAS);
  localparam logic [EXP_W-1:0] EMIN_O = EXP_W'(1 - BIAS);
  localparam logic [EXP_W-1:0] EINF_O = EXP_W'(BIAS + 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t                 state_q, state_d;
  logic [MW-1:0]          m_q, m_d;
  logic signed [EW-1:0]   e_q, e_d;
  logic                   s_q, s_d;
  logic [FRAC_W:0]        n_m_q, n_m_d;
  logic [EXP_W-1:0]       n_e_q, n_e_d;
  logic                   n_s_q, n_s_d;
  logic                   inexact_q, inexact_d;
  logic                   overflow_q, overflow_d;

  logic                   rnd_inc;
  logic [FRAC_W+1:0]      rnd_sum;
  logic [FRAC_W:0]        rnd_m;
  logic signed [EW-1:0]   rnd_e;

  // Round-to-nearest-even on the normalised working mantissa.
  always_comb begin
    rnd_inc = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
    rnd_sum = {1'b0, m_q[MW-2:3]} + (FRAC_W+2)'(rnd_inc);
    rnd_m   = rnd_sum[FRAC_W:0];
    rnd_e   = e_q;
    if (rnd_sum[FRAC_W+1]) begin
      rnd_m = {1'b1, {FRAC_W{1'b0}}};
      rnd_e = e_q + EW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    e_d        = e_q;
    s_d        = s_q;
    n_m_d      = n_m_q;
    n_e_d      = n_e_q;
    n_s_d      = n_s_q;
    inexact_d  = inexact_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = in_m;
          e_d     = {in_e[EXP_W-1], in_e};
          s_d     = in_s;
          state_d = NORM;
        end
      end
      NORM: begin
        if (m_q == '0) begin
          e_d     = EMIN;
          state_d = ROUND;
        end else if (m_q[MW-1] || (e_q < EMIN)) begin
          // Right shift folds the two lowest bits into sticky so no information is lost.
          m_d = {1'b0, m_q[MW-1:2], m_q[1] | m_q[0]};
          e_d = e_q + EW'(1);
        end else if (!m_q[MW-2] && (e_q > EMIN)) begin
          m_d = m_q << 1;
          e_d = e_q - EW'(1);
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        n_s_d = s_q;
        if (rnd_e > EMAX) begin
          n_m_d      = '0;
          n_e_d      = EINF_O;
          overflow_d = 1'b1;
          inexact_d  = 1'b1;
        end else begin
          n_m_d      = rnd_m;
          n_e_d      = rnd_e[EXP_W-1:0];
          overflow_d = 1'b0;
          inexact_d  = |m_q[2:0];
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      m_q        <= '0;
      e_q        <= EMIN;
      s_q        <= 1'b0;
      n_m_q      <= '0;
      n_e_q      <= EMIN_O;
      n_s_q      <= 1'b0;
      inexact_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      e_q        <= e_d;
      s_q        <= s_d;
      n_m_q      <= n_m_d;
      n_e_q      <= n_e_d;
      n_s_q      <= n_s_d;
      inexact_q  <= inexact_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign n_m       = n_m_q;
  assign n_e       = n_e_q;
  assign n_s       = n_s_q;
  assign inexact   = inexact_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Bench for fp_norm_round: directed cases plus random traffic against an exact-arithmetic rounding model.
module tb_fp_norm_round;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] in_m;
  logic [9:0]  in_e;
  logic        in_s;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] n_m;
  logic [9:0]  n_e;
  logic        n_s;
  logic        inexact;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  fp_norm_round dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_m(in_m), .in_e(in_e), .in_s(in_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .n_m(n_m), .n_e(n_e), .n_s(n_s),
    .inexact(inexact), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Exact value is m * 2^(e-26); pick the target exponent, scale to a 24-bit integer, round RNE.
  function automatic void model(input logic [27:0] m, input int e, output int nm, output int ne,
                                output bit inx, output bit ovf, output int sh);
    longint mv, q, rem, half;
    int p, en, et, k;
    bit inc;
    mv  = longint'(m);
    ovf = 1'b0;
    p   = 0;
    if (mv == 0) begin
      nm = 0; ne = -126; inx = 1'b0; sh = 0;
      return;
    end
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    en = e + p - 26;
    et = (en < -126) ? -126 : en;
    sh = (et > e) ? et - e : e - et;
    k  = et - e + 3;
    if (k <= 0) begin
      q = mv << (-k); rem = 0; half = 1;
    end else if (k > 40) begin
      q = 0; rem = 1; half = 2;
    end else begin
      q = mv >> k; rem = mv & ((64'sd1 << k) - 1); half = 64'sd1 << (k - 1);
    end
    inc = (rem > half) || ((rem == half) && q[0]);
    q   = q + longint'(inc);
    inx = (rem != 0);
    if (q == (64'sd1 << 24)) begin
      q  = 64'sd1 << 23;
      et = et + 1;
    end
    if (et > 127) begin
      nm = 0; ne = 128; inx = 1'b1; ovf = 1'b1;
    end else begin
      nm = int'(q); ne = et;
    end
  endfunction

  task automatic run(input logic [27:0] m, input int e, input bit s, input int hold);
    int nm, ne, sh, cnt;
    bit inx, ovf;
    model(m, e, nm, ne, inx, ovf, sh);
    @(negedge clk);
    in_m = m; in_e = e[9:0]; in_s = s; in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 700) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt, 3 + sh);
    check("n_m", n_m, nm);
    check("n_e", $signed(n_e), ne);
    check("n_s", n_s, s);
    check("inexact", inexact, inx);
    check("overflow", overflow, ovf);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_vld", out_valid, 1);
      check("hold_in_rdy", in_ready, 0);
      check("hold_n_m", n_m, nm);
      check("hold_n_e", $signed(n_e), ne);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handover_vld", out_valid, 0);
  endtask

  initial begin
    logic [27:0] rm;
    int re;
    rst = 1'b1; in_valid = 1'b0; in_m = '0; in_e = '0; in_s = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_n_m", n_m, 0);
    check("rst_n_e", $signed(n_e), -126);
    check("rst_flags", {inexact, overflow, n_s}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run(28'h4000000, 0, 1'b0, 5);
    run(28'h091A2B0, 10, 1'b0, 0);
    run(28'h8000008, 5, 1'b1, 0);
    run(28'h7FFFFFC, 3, 1'b0, 0);
    run(28'h7FFFFFC, 127, 1'b0, 2);
    run(28'h0000008, -126, 1'b0, 0);
    run(28'h0000000, 40, 1'b1, 0);
    run(28'h4000000, -127, 1'b0, 0);
    run(28'h3FFFFFC, -126, 1'b0, 0);
    run(28'h0000001, -150, 1'b0, 0);

    // Abort a long left-shift run with reset and make sure nothing leaks out.
    @(negedge clk);
    in_m = 28'h0000100; in_e = 10'd100; in_s = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_n_m", n_m, 0);
    check("abort_n_e", $signed(n_e), -126);
    check("abort_vld", out_valid, 0);
    check("abort_in_rdy", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_hold_vld", out_valid, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_rdy", in_ready, 1);
    check("post_rst_vld", out_valid, 0);
    run(28'h4000000, 0, 1'b0, 0);

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0: rm = 28'($urandom);
        1: rm = 28'($urandom) >> $urandom_range(0, 27);
        2: rm = {1'b0, 3'b111, 24'($urandom)} | 28'h3;
        default: rm = 28'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 3))
        0: re = $urandom_range(0, 300) - 150;
        1: re = $urandom_range(120, 140);
        2: re = $urandom_range(0, 40) - 160;
        default: re = $urandom_range(0, 20) - 10;
      endcase
      run(rm, re, 1'($urandom), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Iterative normalise-and-round stage for single-precision results.
- Sits directly upstream of the bit-packing stage. It takes a raw mantissa from the add/mul datapath, with a carry bit and guard/round/sticky bits, plus an unbiased exponent and a sign.
- It produces a rounded 24-bit mantissa (hidden bit at bit 23), a signed unbiased exponent and a sign, in exactly the form the packer consumes.
- It uses a valid/ready handshake on both sides and shifts by one bit per cycle.

Parameters:
- FRAC_W, 23, stored fraction width; output mantissa is FRAC_W+1 bits, input mantissa is FRAC_W+5 bits.
- EXP_W, 10, signed unbiased exponent width (two's complement) on input and output.
- BIAS, 127, exponent bias; EMIN = 1-BIAS (-126), EMAX = BIAS (127).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  block can accept an input.
- in_m  in  FRAC_W+5  raw mantissa. [27] carry, [26] hidden, [25:3] fraction, [2] G, [1] R, [0] S. Value = in_m/2^26 * 2^in_e.
- in_e  in  EXP_W  signed unbiased exponent.
- in_s  in  1  sign.
- out_valid  out  1  rounded result valid.
- out_ready  in  1  downstream (packer side) accepts.
- n_m  out  FRAC_W+1  rounded mantissa, hidden bit at [23].
- n_e  out  EXP_W  signed unbiased exponent. Denormal/zero = EMIN with n_m[23]=0; infinity = EMAX+1 with n_m=0.
- n_s  out  1  sign, passed through.
- inexact  out  1  G|R|S nonzero at rounding, or overflow.
- overflow  out  1  result rounded to infinity.

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - state=IDLE;
  - out_valid, n_m, n_s, inexact, overflow = 0;
  - n_e = EMIN;
  - in_ready = 0.
- Working registers: m (28 bits), e (EXP_W+1 bits, so it cannot wrap), s.
- States: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: load m, e, s, go to NORM. An input is accepted only in IDLE.
- NORM: exactly one action per cycle, in this priority order:
  - (a) m==0: e=EMIN, go to ROUND.
  - (b) m[27]=1: m = {0, m[27:1]} with bit0 = m[1]|m[0] (sticky), e=e+1.
  - (c) e<EMIN: right-shift with sticky as in (b), e=e+1.
  - (d) m[26]=0 and e>EMIN: m=m<<1, e=e-1.
  - (e) otherwise go to ROUND.
  - Left shifts stop at EMIN, which yields a denormal. Sticky is never lost.
- ROUND: round-to-nearest-even.
  - L=m[3], G=m[2], R=m[1], S=m[0]; inc = G&(R|S|L).
  - r = m[26:3] + inc, computed 25 bits wide.
  - If r[24]: r = 0x800000, e=e+1.
  - A denormal 0x7FFFFF rounding up to 0x800000 keeps e=EMIN; it becomes the smallest normal.
  - If e>EMAX: n_m=0, n_e=EMAX+1, overflow=1, inexact=1.
  - Else: n_m=r, n_e=e, inexact=G|R|S.
  - Register outputs, go to DONE.
- DONE:
  - out_valid=1; all outputs held stable until out_ready.
  - On out_valid&out_ready: out_valid=0 next cycle, go to IDLE.
  - No new input is accepted in the handover cycle.
- Latency: from the accept edge to out_valid is 3 cycles, plus 1 per shift.
  - Max left-shift run is 26 cycles.
  - Right-shift run is bounded by EMIN - in_e.
- Reset mid-operation (any state): immediate abort; the in-flight result is discarded and never presented.
- Outputs change only on ROUND→DONE or on reset.

Test Plan:
- 1.0 path: in_m=0x4000000, in_e=0, in_s=0. Expect n_m=0x800000, n_e=0, n_s=0, inexact=0, overflow=0. out_valid rises 3 cycles after accept.
- Left normalise: in_m=0x091A2B0, in_e=10. Expect n_m=0x91A2B0, n_e=7, inexact=0. Latency 6 cycles (3 left shifts).
- Carry plus tie-to-even: in_m=0x8000008, in_e=5, in_s=1. After the right shift, GRS=100 and L=0, so no increment. Expect n_m=0x800000, n_e=6, n_s=1, inexact=1.
- Round carry and overflow:
  - in_m=0x7FFFFFC, in_e=3: expect n_m=0x800000, n_e=4, inexact=1.
  - Same in_m with in_e=127: expect n_m=0, n_e=128, overflow=1.
- Denormal and zero:
  - in_m=0x0000008, in_e=-126: expect n_m=0x000001, n_e=-126, no shifts.
  - in_m=0, in_e=40: expect n_m=0, n_e=-126.
  - in_m=0x4000000, in_e=-127: expect one right shift, n_m=0x400000, n_e=-126.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE: outputs stable, in_ready=0.
  - Assert rst during a NORM left-shift run: out_valid stays 0, n_m=0 and n_e=-126 immediately.
  - After rst falls: in_ready=1 and the next input completes correctly.
